// File: rtl/hicore_icb_sram_rsp_pkg.sv
// Shared configuration macros and types for the ICB SRAM responder.
// HiCore_DTCM_BASE / HiCore_DTCM_DEPTH supply the responder's default placement.
`ifndef HiCore_ADDR_SIZE
`define HiCore_ADDR_SIZE 32
`endif
`ifndef HiCore_REG_SIZE
`define HiCore_REG_SIZE 32
`endif
`ifndef HiCore_DTCM_BASE
`define HiCore_DTCM_BASE 32'h8000_0000
`endif
`ifndef HiCore_DTCM_DEPTH
`define HiCore_DTCM_DEPTH 1024
`endif

package hicore_icb_sram_rsp_pkg;

    localparam int ADDR_W = `HiCore_ADDR_SIZE;
    localparam int REG_W  = `HiCore_REG_SIZE;
    localparam int MASK_W = REG_W / 8;

    // One queued response: error flag above the read word.
    typedef struct packed {
        logic             err;
        logic [REG_W-1:0] rdata;
    } rsp_ent_t;

    localparam int RSP_ENT_W = $bits(rsp_ent_t);

    function automatic logic [REG_W-1:0] apply_wmask(
        input logic [REG_W-1:0]  old_word,
        input logic [REG_W-1:0]  wdata,
        input logic [MASK_W-1:0] wmask
    );
        logic [REG_W-1:0] merged;
        merged = old_word;
        for (int b = 0; b < MASK_W; b++) begin
            if (wmask[b]) merged[8*b +: 8] = wdata[8*b +: 8];
        end
        return merged;
    endfunction

endpackage

// File: rtl/hicore_icb_rsp_fifo.sv
// In-order response FIFO: registered entries, head presented directly, no bypass.
// Pointers wrap modulo DP so non-power-of-two depths work.
module hicore_icb_rsp_fifo #(
    parameter int DW    = 33,
    parameter int DP    = 2,
    parameter int LOGDP = 1,
    parameter int CNTW  = $clog2(DP + 1)
) (
    input  logic            clk,
    input  logic            rst_n,
    input  logic            push_i,
    input  logic [DW-1:0]   push_data_i,
    input  logic            pop_i,
    output logic [DW-1:0]   head_o,
    output logic            full_o,
    output logic            empty_o,
    output logic [CNTW-1:0] cnt_o
);

    localparam int PW = (LOGDP > 0) ? LOGDP : 1;

    logic [DW-1:0]   data_q [DP];
    logic [PW-1:0]   rd_ptr_q, rd_ptr_d;
    logic [PW-1:0]   wr_ptr_q, wr_ptr_d;
    logic [CNTW-1:0] cnt_q, cnt_d;

    function automatic logic [PW-1:0] ptr_inc(input logic [PW-1:0] p);
        return (p == PW'(DP - 1)) ? '0 : p + 1'b1;
    endfunction

    always_comb begin
        rd_ptr_d = rd_ptr_q;
        wr_ptr_d = wr_ptr_q;
        cnt_d    = cnt_q;
        if (push_i) wr_ptr_d = ptr_inc(wr_ptr_q);
        if (pop_i)  rd_ptr_d = ptr_inc(rd_ptr_q);
        case ({push_i, pop_i})
            2'b10:   cnt_d = cnt_q + 1'b1;
            2'b01:   cnt_d = cnt_q - 1'b1;
            default: cnt_d = cnt_q;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            rd_ptr_q <= '0;
            wr_ptr_q <= '0;
            cnt_q    <= '0;
        end else begin
            rd_ptr_q <= rd_ptr_d;
            wr_ptr_q <= wr_ptr_d;
            cnt_q    <= cnt_d;
        end
    end

    // Entries are cleared on reset so the head reads as zero until first use.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < DP; i++) data_q[i] <= '0;
        end else if (push_i) begin
            data_q[wr_ptr_q] <= push_data_i;
        end
    end

    assign head_o  = data_q[rd_ptr_q];
    assign full_o  = (cnt_q == CNTW'(DP));
    assign empty_o = (cnt_q == '0);
    assign cnt_o   = cnt_q;

endmodule

// File: rtl/hicore_icb_sram_rsp.sv
// ICB slave for the data-memory port: word SRAM plus in-order response FIFO.
// Optional HICORE_ICB_SRAM_WAIT_EN holds each new head for WAIT_CYC cycles.
module hicore_icb_sram_rsp
    import hicore_icb_sram_rsp_pkg::*;
#(
    parameter logic [`HiCore_ADDR_SIZE-1:0] BASE_ADDR = `HiCore_DTCM_BASE,
    parameter int DEPTH    = `HiCore_DTCM_DEPTH,
    parameter int LOGDEPTH = 10,
    parameter int RSP_DP   = 2,
    parameter int WAIT_CYC = 2
) (
    input  logic                          clk,
    input  logic                          rst_n,
    input  logic                          mem_icb_cmd_valid,
    output logic                          mem_icb_cmd_ready,
    input  logic                          mem_icb_cmd_read,
    input  logic [`HiCore_ADDR_SIZE-1:0]  mem_icb_cmd_addr,
    input  logic [`HiCore_REG_SIZE-1:0]   mem_icb_cmd_wdata,
    input  logic [`HiCore_REG_SIZE/8-1:0] mem_icb_cmd_wmask,
    output logic                          mem_icb_rsp_valid,
    input  logic                          mem_icb_rsp_ready,
    output logic                          mem_icb_rsp_err,
    output logic [`HiCore_REG_SIZE-1:0]   mem_icb_rsp_rdata
);

    localparam int CNTW  = $clog2(RSP_DP + 1);
    localparam int LOGDP = (RSP_DP > 1) ? $clog2(RSP_DP) : 1;
    localparam logic [ADDR_W:0] SPAN = (ADDR_W + 1)'(4 * DEPTH);

    logic [REG_W-1:0]    mem_q [DEPTH];
    logic [ADDR_W:0]     addr_off;
    logic                in_range;
    logic [LOGDEPTH-1:0] word_idx;
    logic [REG_W-1:0]    rd_word;
    logic                mem_we;

    logic                cmd_hs, rsp_hs;
    logic                fifo_full, fifo_empty, head_ok;
    logic [CNTW-1:0]     fifo_cnt;
    rsp_ent_t            push_ent, head_ent;

    // Extra top bit catches addresses below BASE_ADDR as a borrow.
    assign addr_off = {1'b0, mem_icb_cmd_addr} - {1'b0, BASE_ADDR};
    assign in_range = ~addr_off[ADDR_W] & (addr_off < SPAN);
    assign word_idx = addr_off[LOGDEPTH+1:2];
    assign rd_word  = mem_q[word_idx];

    assign rsp_hs            = mem_icb_rsp_valid & mem_icb_rsp_ready;
    assign mem_icb_cmd_ready = ~fifo_full | rsp_hs;
    assign cmd_hs            = mem_icb_cmd_valid & mem_icb_cmd_ready;

    // Gated by rst_n so a command presented during reset never reaches the array.
    assign mem_we = cmd_hs & ~mem_icb_cmd_read & in_range & rst_n;

    always_ff @(posedge clk) begin
        if (mem_we) begin
            mem_q[word_idx] <= apply_wmask(mem_q[word_idx], mem_icb_cmd_wdata, mem_icb_cmd_wmask);
        end
    end

    always_comb begin
        push_ent.err   = ~in_range;
        push_ent.rdata = (in_range & mem_icb_cmd_read) ? rd_word : '0;
    end

    hicore_icb_rsp_fifo #(
        .DW    (RSP_ENT_W),
        .DP    (RSP_DP),
        .LOGDP (LOGDP),
        .CNTW  (CNTW)
    ) u_rsp_fifo (
        .clk         (clk),
        .rst_n       (rst_n),
        .push_i      (cmd_hs),
        .push_data_i (push_ent),
        .pop_i       (rsp_hs),
        .head_o      (head_ent),
        .full_o      (fifo_full),
        .empty_o     (fifo_empty),
        .cnt_o       (fifo_cnt)
    );

`ifdef HICORE_ICB_SRAM_WAIT_EN
    localparam int WCW = (WAIT_CYC > 1) ? $clog2(WAIT_CYC + 1) : 1;

    logic [WCW-1:0] wait_q, wait_d;
    logic           head_load;

    // A fresh head appears on push into empty, or on a pop that leaves entries behind.
    always_comb begin
        head_load = (cmd_hs & fifo_empty) | (rsp_hs & ((fifo_cnt > CNTW'(1)) | cmd_hs));
        wait_d    = wait_q;
        if (head_load)          wait_d = WCW'(WAIT_CYC);
        else if (wait_q != '0)  wait_d = wait_q - 1'b1;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) wait_q <= '0;
        else        wait_q <= wait_d;
    end

    assign head_ok = (wait_q == '0);
`else
    localparam int unused_wait_cyc = WAIT_CYC;
    logic unused_cnt;
    assign unused_cnt = ^fifo_cnt;
    assign head_ok    = 1'b1;
`endif

    assign mem_icb_rsp_valid = ~fifo_empty & head_ok;
    assign mem_icb_rsp_err   = head_ent.err;
    assign mem_icb_rsp_rdata = head_ent.rdata;

endmodule

// File: tb/tb_hicore_icb_sram_rsp.sv
// Randomised bench for hicore_icb_sram_rsp with a queue/array reference model,
// plus directed scenarios pinning literal values, backpressure and reset behaviour.
module tb_hicore_icb_sram_rsp;

    localparam logic [31:0] BASE   = 32'h8000_0000;
    localparam int          DEPTH  = 1024;
    localparam int          RSP_DP = 2;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        cmd_valid = 1'b0;
    logic        cmd_ready;
    logic        cmd_read = 1'b0;
    logic [31:0] cmd_addr = '0;
    logic [31:0] cmd_wdata = '0;
    logic [3:0]  cmd_wmask = '0;
    logic        rsp_valid;
    logic        rsp_ready = 1'b1;
    logic        rsp_err;
    logic [31:0] rsp_rdata;

    int          checks = 0;
    int          failures = 0;
    int          cyc = 0;
    logic        rand_phase = 1'b0;

    logic [32:0] exp_q[$];
    logic [31:0] model_mem [int];

    hicore_icb_sram_rsp #(
        .BASE_ADDR (BASE),
        .DEPTH     (DEPTH),
        .LOGDEPTH  (10),
        .RSP_DP    (RSP_DP),
        .WAIT_CYC  (2)
    ) dut (
        .clk               (clk),
        .rst_n             (rst_n),
        .mem_icb_cmd_valid (cmd_valid),
        .mem_icb_cmd_ready (cmd_ready),
        .mem_icb_cmd_read  (cmd_read),
        .mem_icb_cmd_addr  (cmd_addr),
        .mem_icb_cmd_wdata (cmd_wdata),
        .mem_icb_cmd_wmask (cmd_wmask),
        .mem_icb_rsp_valid (rsp_valid),
        .mem_icb_rsp_ready (rsp_ready),
        .mem_icb_rsp_err   (rsp_err),
        .mem_icb_rsp_rdata (rsp_rdata)
    );

    // ---------------- clock / reset ----------------
    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] req);
        checks++;
        if (act !== req) begin
            failures++;
            $display("FAIL %s actual=%0h required=%0h time=%0t", name, act, req, $time);
        end
    endtask

    // ---------------- scoreboard / reference model ----------------
    // Outputs are sampled on the falling edge; handshakes seen here take effect at the next rising edge.
    always @(negedge clk) begin
        if (!rst_n) begin
            exp_q.delete();
        end else begin
            longint      a;
            logic        in_rng;
            int          idx;
            logic [31:0] word;
            check("rsp_valid", rsp_valid, exp_q.size() != 0);
            check("cmd_ready", cmd_ready, (exp_q.size() < RSP_DP) || (exp_q.size() != 0 && rsp_ready));
            if (rsp_valid && exp_q.size() != 0) check("rsp_head", {rsp_err, rsp_rdata}, exp_q[0]);
            if (rsp_valid && rsp_ready && exp_q.size() != 0) void'(exp_q.pop_front());
            if (cmd_valid && cmd_ready) begin
                a      = longint'(cmd_addr);
                in_rng = (a >= longint'(BASE)) && (a < longint'(BASE) + 4 * DEPTH);
                idx    = int'((a - longint'(BASE)) >>> 2);
                if (!in_rng) begin
                    exp_q.push_back({1'b1, 32'h0});
                end else if (cmd_read) begin
                    word = model_mem.exists(idx) ? model_mem[idx] : 32'h0;
                    exp_q.push_back({1'b0, word});
                end else begin
                    word = model_mem.exists(idx) ? model_mem[idx] : 32'h0;
                    for (int b = 0; b < 4; b++) begin
                        if (cmd_wmask[b]) word[8*b +: 8] = cmd_wdata[8*b +: 8];
                    end
                    model_mem[idx] = word;
                    exp_q.push_back({1'b0, 32'h0});
                end
            end
        end
    end

    // Random backpressure while the random phase runs.
    always @(posedge clk) begin
        if (rand_phase) begin
            #1;
            rsp_ready = ($urandom_range(0, 3) != 0);
        end
    end

    // ---------------- driver tasks ----------------
    // All tasks start and end at rising edge + 1.
    task automatic send(input logic rd, input logic [31:0] a, input logic [31:0] d,
                        input logic [3:0] m, output int acc);
        int   n;
        logic r;
        cmd_valid = 1'b1;
        cmd_read  = rd;
        cmd_addr  = a;
        cmd_wdata = d;
        cmd_wmask = m;
        n = 0;
        r = 1'b0;
        while (!r && n < 200) begin
            @(negedge clk);
            r = cmd_ready;
            @(posedge clk);
            #1;
            n++;
        end
        check("cmd_accept", r, 1'b1);
        acc       = cyc;
        cmd_valid = 1'b0;
    endtask

    task automatic expect_rsp(input string name, input logic err, input logic [31:0] data);
        int w;
        w = 0;
        do begin
            @(negedge clk);
            w++;
        end while (!rsp_valid && w < 20);
        check({name, "_latency"}, w, 1);
        check({name, "_err"}, rsp_err, err);
        check({name, "_rdata"}, rsp_rdata, data);
        @(posedge clk);
        #1;
    endtask

    task automatic idle(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    // ---------------- main sequence ----------------
    initial begin
        int          acc, c_first, c_last;
        logic [31:0] a;
        int          sel;

        idle(3);
        check("reset_rsp_valid", rsp_valid, 1'b0);
        check("reset_rsp_err", rsp_err, 1'b0);
        check("reset_rsp_rdata", rsp_rdata, 32'h0);
        check("reset_cmd_ready", cmd_ready, 1'b1);
        rst_n = 1'b1;
        idle(1);

        // Give every word touched later a known value.
        for (int i = 0; i < 16; i++) send(1'b0, BASE + 32'(4 * i), $urandom, 4'hF, acc);
        send(1'b0, BASE + 32'hFFC, 32'hCAFE_F00D, 4'hF, acc);
        idle(3);

        // Full write then read-back in the following cycle.
        send(1'b0, 32'h8000_0010, 32'hDEAD_BEEF, 4'hF, acc);
        send(1'b1, 32'h8000_0010, 32'h0, 4'h0, acc);
        expect_rsp("t1_read", 1'b0, 32'hDEAD_BEEF);

        // Single-lane write merges over the old word.
        send(1'b0, 32'h8000_0010, 32'h0000_AA00, 4'b0010, acc);
        send(1'b1, 32'h8000_0010, 32'h0, 4'h0, acc);
        expect_rsp("t2_read", 1'b0, 32'hDEAD_AAEF);

        // Range boundaries; out-of-range write must not alias into word 0.
        send(1'b0, 32'h8000_0000, 32'h1122_3344, 4'hF, acc);
        send(1'b1, 32'h7FFF_FFFC, 32'h0, 4'h0, acc);
        expect_rsp("t3_below", 1'b1, 32'h0);
        send(1'b1, 32'h8000_1000, 32'h0, 4'h0, acc);
        expect_rsp("t3_above", 1'b1, 32'h0);
        send(1'b0, 32'h8000_1000, 32'hFFFF_FFFF, 4'hF, acc);
        send(1'b1, 32'h8000_0000, 32'h0, 4'h0, acc);
        expect_rsp("t3_unchanged", 1'b0, 32'h1122_3344);
        send(1'b1, 32'h8000_0FFF, 32'h0, 4'h0, acc);
        expect_rsp("t3_last_word", 1'b0, 32'hCAFE_F00D);
        send(1'b0, 32'h8000_0000, 32'h5555_5555, 4'h0, acc);
        send(1'b1, 32'h8000_0000, 32'h0, 4'h0, acc);
        expect_rsp("t3_zero_mask", 1'b0, 32'h1122_3344);
        idle(3);

        // Backpressure: two accepts fill the FIFO, third waits for the pop cycle.
        rsp_ready = 1'b0;
        send(1'b1, 32'h8000_0010, 32'h0, 4'h0, acc);
        send(1'b1, 32'h8000_0000, 32'h0, 4'h0, acc);
        cmd_valid = 1'b1;
        cmd_read  = 1'b1;
        cmd_addr  = 32'h8000_0FFC;
        @(negedge clk);
        check("t4_full_ready", cmd_ready, 1'b0);
        @(posedge clk);
        #1;
        rsp_ready = 1'b1;
        @(negedge clk);
        check("t4_pop_ready", cmd_ready, 1'b1);
        check("t4_first", rsp_rdata, 32'hDEAD_AAEF);
        @(posedge clk);
        #1;
        cmd_valid = 1'b0;
        @(negedge clk);
        check("t4_second", rsp_rdata, 32'h1122_3344);
        @(negedge clk);
        check("t4_third", rsp_rdata, 32'hCAFE_F00D);
        idle(3);

        // Back-to-back reads at full throughput.
        send(1'b1, BASE, 32'h0, 4'h0, c_first);
        for (int i = 1; i < 8; i++) send(1'b1, BASE + 32'(4 * i), 32'h0, 4'h0, c_last);
        check("t5_throughput", c_last - c_first, 7);
        idle(3);

        // Reset with two queued responses; a write held during reset must not land.
        rsp_ready = 1'b0;
        send(1'b1, 32'h8000_0010, 32'h0, 4'h0, acc);
        send(1'b1, 32'h8000_0000, 32'h0, 4'h0, acc);
        rst_n     = 1'b0;
        cmd_valid = 1'b1;
        cmd_read  = 1'b0;
        cmd_addr  = 32'h8000_0000;
        cmd_wdata = 32'hFFFF_FFFF;
        cmd_wmask = 4'hF;
        #1;
        check("t6_rst_valid", rsp_valid, 1'b0);
        check("t6_rst_rdata", rsp_rdata, 32'h0);
        check("t6_rst_ready", cmd_ready, 1'b1);
        idle(2);
        cmd_valid = 1'b0;
        rst_n     = 1'b1;
        rsp_ready = 1'b1;
        idle(1);
        send(1'b1, 32'h8000_0000, 32'h0, 4'h0, acc);
        expect_rsp("t6_no_write", 1'b0, 32'h1122_3344);

        // Randomised traffic against the reference model.
        rand_phase = 1'b1;
        for (int i = 0; i < 400; i++) begin
            sel = $urandom_range(0, 9);
            case (sel)
                0: a = 32'h7FFF_FFFC;
                1: a = 32'h8000_1000 + 32'($urandom_range(0, 255));
                2: a = BASE + 32'hFFC + 32'($urandom_range(0, 3));
                default: a = BASE + 32'(4 * $urandom_range(0, 15)) + 32'($urandom_range(0, 3));
            endcase
            send($urandom_range(0, 1) == 1, a, $urandom, 4'($urandom_range(0, 15)), acc);
            if ($urandom_range(0, 3) == 0) idle($urandom_range(1, 2));
        end
        rand_phase = 1'b0;
        @(posedge clk);
        #2;
        rsp_ready = 1'b1;
        for (int i = 0; i < 100 && exp_q.size() != 0; i++) idle(1);
        check("drain", exp_q.size(), 0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
